// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush and data-memory wait hold.
// Also provides a memory timeout FSM and saturating stall/flush event counters.
module pipe_hazard_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        idex_memread_i,
    input  logic [4:0]  idex_rtaddr_i,
    input  logic [4:0]  ifid_rsaddr_i,
    input  logic [4:0]  ifid_rtaddr_i,
    input  logic        branch_taken_i,
    input  logic        jump_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        idex_bubble_o,
    output logic        pipe_hold_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;
    logic        r_timeout;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_mhold;
    logic        w_luse;
    logic        w_br;

    assign w_mhold = ((r_state == ST_RUN) & mem_req_i & ~mem_ack_i)
                   | ((r_state == ST_MEM_WAIT) & ~mem_ack_i)
                   | (r_state == ST_ERR);
    assign w_luse  = idex_memread_i & (idex_rtaddr_i != 5'd0)
                   & ((idex_rtaddr_i == ifid_rsaddr_i) | (idex_rtaddr_i == ifid_rtaddr_i));
    assign w_br    = branch_taken_i | jump_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= 8'd0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            // ERR is only reachable through the wait-counter expiry
            if (w_state_nxt == ST_ERR) begin
                r_timeout <= 1'b1;
            end
            if (!pc_write_o && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (ifid_flush_o && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            ST_RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack_i) begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = 8'd0;
                end else if (r_wait_cnt == 8'hFF) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_hold_o   = 1'b0;
        if (rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (w_mhold) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_hold_o  = 1'b1;
        end else if (w_luse) begin
            // a pending branch is left in IF/ID and resolves again next cycle
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (w_br) begin
            ifid_flush_o = 1'b1;
        end
    end

    assign state_o     = r_state;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
    assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; expectations are queued by the stimulus
// and popped by a negedge monitor that compares every output.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        idex_memread = 1'b0;
    logic [4:0]  idex_rtaddr = 5'd0;
    logic [4:0]  ifid_rsaddr = 5'd0;
    logic [4:0]  ifid_rtaddr = 5'd0;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ack = 1'b0;
    logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;
    logic        timeout_o;

    // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
    localparam logic [4:0] C_NORM = 5'b11000;
    localparam logic [4:0] C_LUSE = 5'b00010;
    localparam logic [4:0] C_BR   = 5'b11100;
    localparam logic [4:0] C_HOLD = 5'b00001;
    localparam logic [4:0] C_RST  = 5'b00010;

    typedef struct packed {
        logic [31:0] id;
        logic [4:0]  ctl;
        logic [1:0]  st;
        logic        to;
        logic [15:0] stall;
        logic [15:0] flush;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          step_no = 0;
    logic [15:0] m_stall = 16'd0;
    logic [15:0] m_flush = 16'd0;
    logic        prev_rst = 1'b1;
    logic        prev_pcw = 1'b0;
    logic        prev_flush = 1'b0;
    exp_t        mon_e;
    logic [7:0]  mon_got_c;
    logic [7:0]  mon_req_c;

    pipe_hazard_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .idex_memread_i (idex_memread),
        .idex_rtaddr_i  (idex_rtaddr),
        .ifid_rsaddr_i  (ifid_rsaddr),
        .ifid_rtaddr_i  (ifid_rtaddr),
        .branch_taken_i (branch_taken),
        .jump_i         (jump),
        .mem_req_i      (mem_req),
        .mem_ack_i      (mem_ack),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .pipe_hold_o    (pipe_hold_o),
        .state_o        (state_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e     = q.pop_front();
            mon_got_c = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
                         state_o, timeout_o};
            mon_req_c = {mon_e.ctl, mon_e.st, mon_e.to};
            checks++;
            if (mon_got_c !== mon_req_c || stall_cnt_o !== mon_e.stall || flush_cnt_o !== mon_e.flush) begin
                errors++;
                $display("FAIL step%0d pcw,ifw,flush,bub,hold,st,to got=%b required=%b stall got=%h required=%h flush got=%h required=%h",
                         mon_e.id, mon_got_c, mon_req_c, stall_cnt_o, mon_e.stall, flush_cnt_o, mon_e.flush);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!prev_rst) begin
            if (!prev_pcw && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (prev_flush && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
        end
        #1;
    endtask

    task automatic set_in(input logic memrd, input logic [4:0] idrt, input logic [4:0] rs,
                          input logic [4:0] rt, input logic br, input logic jmp,
                          input logic req, input logic ack);
        idex_memread = memrd;
        idex_rtaddr  = idrt;
        ifid_rsaddr  = rs;
        ifid_rtaddr  = rt;
        branch_taken = br;
        jump         = jmp;
        mem_req      = req;
        mem_ack      = ack;
    endtask

    task automatic chk_out(input logic [4:0] ctl, input logic [1:0] st, input logic to, input bit chk);
        exp_t e;
        if (rst) begin
            m_stall = 16'd0;
            m_flush = 16'd0;
        end
        e.id    = step_no;
        e.ctl   = ctl;
        e.st    = st;
        e.to    = to;
        e.stall = m_stall;
        e.flush = m_flush;
        step_no++;
        if (chk) q.push_back(e);
        prev_rst   = rst;
        prev_pcw   = ctl[4];
        prev_flush = ctl[2];
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at step %0d", step_no);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        tick(); chk_out(C_RST, 2'b00, 1'b0, 1'b1);
        tick(); rst = 1'b0; set_in(0, 0, 0, 0, 0, 0, 0, 0); chk_out(C_NORM, 2'b00, 1'b0, 1'b1);
        // load-use on rs, then same with rt=0
        tick(); set_in(1, 5, 5, 0, 0, 0, 0, 0); chk_out(C_LUSE, 2'b00, 1'b0, 1'b1);
        tick(); set_in(1, 0, 0, 0, 0, 0, 0, 0); chk_out(C_NORM, 2'b00, 1'b0, 1'b1);
        // load-use on rt, then together with a taken branch
        tick(); set_in(1, 7, 3, 7, 0, 0, 0, 0); chk_out(C_LUSE, 2'b00, 1'b0, 1'b1);
        tick(); set_in(1, 7, 3, 7, 1, 0, 0, 0); chk_out(C_LUSE, 2'b00, 1'b0, 1'b1);
        tick(); set_in(0, 7, 3, 7, 1, 0, 0, 0); chk_out(C_BR,   2'b00, 1'b0, 1'b1);
        tick(); set_in(0, 0, 0, 0, 0, 1, 0, 0); chk_out(C_BR,   2'b00, 1'b0, 1'b1);
        tick(); set_in(0, 9, 9, 9, 0, 0, 0, 0); chk_out(C_NORM, 2'b00, 1'b0, 1'b1);
        // three-cycle memory wait; hold outranks load-use and branch
        tick(); set_in(1, 4, 4, 0, 1, 0, 1, 0); chk_out(C_HOLD, 2'b00, 1'b0, 1'b1);
        tick(); set_in(1, 4, 4, 0, 0, 1, 1, 0); chk_out(C_HOLD, 2'b01, 1'b0, 1'b1);
        tick(); set_in(0, 0, 0, 0, 0, 0, 1, 0); chk_out(C_HOLD, 2'b01, 1'b0, 1'b1);
        tick(); set_in(0, 0, 0, 0, 0, 0, 1, 1); chk_out(C_NORM, 2'b01, 1'b0, 1'b1);
        tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0); chk_out(C_NORM, 2'b00, 1'b0, 1'b1);
        // request acked in the same cycle from RUN
        tick(); set_in(0, 0, 0, 0, 0, 0, 1, 1); chk_out(C_NORM, 2'b00, 1'b0, 1'b1);
        tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0); chk_out(C_NORM, 2'b00, 1'b0, 1'b1);
        // branch in the ack cycle of a wait is flushed immediately
        tick(); set_in(0, 0, 0, 0, 0, 0, 1, 0); chk_out(C_HOLD, 2'b00, 1'b0, 1'b1);
        tick(); set_in(0, 0, 0, 0, 1, 0, 1, 1); chk_out(C_BR,   2'b01, 1'b0, 1'b1);
        tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0); chk_out(C_NORM, 2'b00, 1'b0, 1'b1);
        // timeout path
        tick(); set_in(0, 0, 0, 0, 0, 0, 1, 0); chk_out(C_HOLD, 2'b00, 1'b0, 1'b1);
        for (int i = 1; i <= 255; i++) begin
            tick(); chk_out(C_HOLD, 2'b01, 1'b0, (i == 1) || (i == 255));
        end
        tick(); chk_out(C_HOLD, 2'b10, 1'b1, 1'b1);
        tick(); set_in(0, 0, 0, 0, 1, 0, 0, 1); chk_out(C_HOLD, 2'b10, 1'b1, 1'b1);
        for (int i = 0; i < 69800; i++) begin
            tick(); chk_out(C_HOLD, 2'b10, 1'b1, (i % 8192) == 0 || i >= 69795);
        end
        // reset pulse clears ERR and counters
        tick(); rst = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0, 0); chk_out(C_RST, 2'b00, 1'b0, 1'b1);
        tick(); rst = 1'b0; chk_out(C_NORM, 2'b00, 1'b0, 1'b1);
        // reset asserted mid-cycle in MEM_WAIT
        tick(); set_in(0, 0, 0, 0, 0, 0, 1, 0); chk_out(C_HOLD, 2'b00, 1'b0, 1'b1);
        tick(); chk_out(C_HOLD, 2'b01, 1'b0, 1'b1);
        tick(); chk_out(C_HOLD, 2'b01, 1'b0, 1'b0);
        #2; rst = 1'b1; chk_out(C_RST, 2'b00, 1'b0, 1'b1);
        tick(); rst = 1'b0; chk_out(C_HOLD, 2'b00, 1'b0, 1'b1);
        tick(); set_in(0, 0, 0, 0, 0, 0, 1, 1); chk_out(C_NORM, 2'b01, 1'b0, 1'b1);
        tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0); chk_out(C_NORM, 2'b00, 1'b0, 1'b1);
        tick();
        tick();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain pending=%0d required=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
